// File: rtl/pixel_pio_bridge_if.sv
// rtl/pixel_pio_bridge_if.sv - pixel stream bundle: input beats and one-cycle-delayed output beats
interface pixel_pio_bridge_if;
  logic       vid_valid;
  logic       vid_sof;
  logic       vid_eol;
  logic [7:0] vid_r;
  logic [7:0] vid_g;
  logic [7:0] vid_b;
  logic       out_valid;
  logic       out_sof;
  logic       out_eol;
  logic [7:0] out_r;
  logic [7:0] out_g;
  logic [7:0] out_b;

  modport master (
    output vid_valid, vid_sof, vid_eol, vid_r, vid_g, vid_b,
    input  out_valid, out_sof, out_eol, out_r, out_g, out_b
  );

  modport slave (
    input  vid_valid, vid_sof, vid_eol, vid_r, vid_g, vid_b,
    output out_valid, out_sof, out_eol, out_r, out_g, out_b
  );
endinterface

// File: rtl/pixel_pio_bridge.sv
// rtl/pixel_pio_bridge.sv - video passthrough with marker overlay and toggle-handshake pixel capture for a Nios PIO
module pixel_pio_bridge #(
  parameter int TIMEOUT_FRAMES = 3
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  pixel_pio_bridge_if.slave  vid,
  output logic [7:0]         red_in_port,
  output logic [7:0]         green_in_port,
  output logic [7:0]         blue_in_port,
  output logic [17:0]        sw_in_port,
  input  logic [7:0]         red_out_port,
  input  logic [7:0]         green_out_port,
  input  logic [7:0]         blue_out_port,
  input  logic [17:0]        sw_out_port
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_SOF = 2'd1;
  localparam logic [1:0] ST_SCAN     = 2'd2;
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_FRAMES);

  logic [1:0]  state;
  logic [9:0]  pos_x, pos_y, cur_x, cur_y;
  logic [9:0]  tgt_x, tgt_y;
  logic [9:0]  eol_cnt, line_cnt;
  logic [15:0] frame_cnt;
  logic        seen_sof, req_q, ack, error, cap_valid;
  logic        sof_beat, eol_beat, req, hit, mark, scanning;
  logic        unused_cmd_bits;

  // A sof beat is (0,0) regardless of where the free-running counters are.
  assign sof_beat = vid.vid_valid & vid.vid_sof;
  assign eol_beat = vid.vid_valid & vid.vid_eol;
  assign cur_x    = sof_beat ? 10'd0 : pos_x;
  assign cur_y    = sof_beat ? 10'd0 : pos_y;
  assign req      = sw_out_port[17] ^ req_q;
  assign hit      = vid.vid_valid && (cur_x == tgt_x) && (cur_y == tgt_y);
  assign mark     = vid.vid_valid && sw_out_port[15] && ((cur_x == tgt_x) || (cur_y == tgt_y));
  assign scanning = (state == ST_SCAN) || ((state == ST_WAIT_SOF) && sof_beat);
  assign unused_cmd_bits = ^sw_out_port[14:10];

  assign sw_in_port = {ack, state != ST_IDLE, error, cap_valid, 4'b0000, line_cnt};

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (vid.vid_valid) begin
      if (vid.vid_eol) begin
        pos_x <= '0;
        pos_y <= cur_y + 10'd1;
      end else begin
        pos_x <= cur_x + 10'd1;
        pos_y <= cur_y;
      end
    end
  end

  // Partial frame before the first sof is not reported as a line count.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      eol_cnt  <= '0;
      line_cnt <= '0;
      seen_sof <= 1'b0;
    end else if (sof_beat) begin
      line_cnt <= seen_sof ? eol_cnt : 10'd0;
      seen_sof <= 1'b1;
      eol_cnt  <= 10'(vid.vid_eol);
    end else if (eol_beat && (eol_cnt != 10'd1023)) begin
      eol_cnt <= eol_cnt + 10'd1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state         <= ST_IDLE;
      req_q         <= 1'b0;
      ack           <= 1'b0;
      error         <= 1'b0;
      cap_valid     <= 1'b0;
      tgt_x         <= '0;
      tgt_y         <= '0;
      frame_cnt     <= '0;
      red_in_port   <= '0;
      green_in_port <= '0;
      blue_in_port  <= '0;
    end else begin
      req_q <= sw_out_port[17];
      if (req) begin
        // A new command always preempts an in-flight capture without acking it.
        if (!sw_out_port[16]) begin
          tgt_x <= sw_out_port[9:0];
          ack   <= ~ack;
          state <= ST_IDLE;
        end else begin
          tgt_y     <= sw_out_port[9:0];
          error     <= 1'b0;
          cap_valid <= 1'b0;
          frame_cnt <= '0;
          state     <= ST_WAIT_SOF;
        end
      end else if (scanning) begin
        state <= ST_SCAN;
        if (hit) begin
          red_in_port   <= vid.vid_r;
          green_in_port <= vid.vid_g;
          blue_in_port  <= vid.vid_b;
          cap_valid     <= 1'b1;
          ack           <= ~ack;
          state         <= ST_IDLE;
        end else if (sof_beat && (state == ST_SCAN)) begin
          if (frame_cnt + 16'd1 >= TIMEOUT_LIM) begin
            error <= 1'b1;
            ack   <= ~ack;
            state <= ST_IDLE;
          end else begin
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      vid.out_valid <= 1'b0;
      vid.out_sof   <= 1'b0;
      vid.out_eol   <= 1'b0;
      vid.out_r     <= '0;
      vid.out_g     <= '0;
      vid.out_b     <= '0;
    end else begin
      vid.out_valid <= vid.vid_valid;
      vid.out_sof   <= vid.vid_sof;
      vid.out_eol   <= vid.vid_eol;
      vid.out_r     <= mark ? red_out_port   : vid.vid_r;
      vid.out_g     <= mark ? green_out_port : vid.vid_g;
      vid.out_b     <= mark ? blue_out_port  : vid.vid_b;
    end
  end

endmodule

// File: doc/pixel_pio_bridge.md
PIXEL_PIO_BRIDGE -- requirements
Module: pixel_pio_bridge

Interface
REQ-001 Parameter TIMEOUT_FRAMES, default 3: number of start-of-frame beats seen while scanning before an armed capture aborts with an error.
REQ-002 clk_clk  in  1  sole clock; all logic on rising edge.
REQ-003 reset_reset_n  in  1  reset, synchronous, active-low.
REQ-004 vid_valid  in  1  input pixel beat valid.
REQ-005 vid_sof  in  1  start of frame; qualified by vid_valid; marks the first pixel, position (0,0).
REQ-006 vid_eol  in  1  end of line; qualified by vid_valid; marks the last pixel of a line.
REQ-007 vid_r, vid_g, vid_b  in  8 each  input pixel colour.
REQ-008 out_valid, out_sof, out_eol  out  1 each  output stream controls.
REQ-009 out_r, out_g, out_b  out  8 each  output pixel colour.
REQ-010 red_in_port, green_in_port, blue_in_port  out  8 each  captured pixel to Nios PIO.
REQ-011 sw_in_port  out  18  status to Nios: [17] ack toggle, [16] busy, [15] error, [14] capture valid, [13:10] zero, [9:0] line count of last frame.
REQ-012 red_out_port, green_out_port, blue_out_port  in  8 each  marker colour from Nios.
REQ-013 sw_out_port  in  18  command from Nios: [17] req toggle, [16] cmd (0 = set X, 1 = set Y and arm), [15] marker enable, [9:0] value; [14:10] ignored.

Function
REQ-014 Position counters: the beat with vid_valid & vid_sof has position (0,0); each further valid beat increments x; after a valid eol beat, x = 0 and y increments; x and y are 10 bits and wrap modulo 1024.
REQ-015 Line count: on each valid sof beat, sw_in_port[9:0] loads the number of eol beats since the previous sof, saturating at 1023; the count is 0 until the first frame completes.
REQ-016 Command detection: the block registers sw_out_port[17] each cycle; a change versus the previous cycle is one request, decoded in that cycle.
REQ-017 cmd 0 (set X): X loads value[9:0]; the ack toggle inverts on the following cycle; state is unchanged.
REQ-018 cmd 1 (arm): Y loads value[9:0]; error and capture valid clear; the frame counter clears; state goes to WAIT_SOF; busy = 1; no ack yet.
REQ-019 States: IDLE (busy 0), WAIT_SOF (busy 1), SCAN (busy 1).
REQ-020 WAIT_SOF: on a valid sof beat, go to SCAN, and the same beat is also evaluated for a match.
REQ-021 SCAN match: a valid beat at x == X and y == Y latches vid_r/g/b into red/green/blue_in_port and sets capture valid = 1; the ack toggle inverts; state goes to IDLE; all updates occur on the clock edge ending that beat.
REQ-022 SCAN timeout: each valid sof beat after entry increments the frame counter; when it reaches TIMEOUT_FRAMES, error = 1, the ack toggle inverts, state goes to IDLE, and the pixel ports hold their old values.
REQ-023 Simultaneous match and timeout on the same sof beat: the match wins.
REQ-024 Request while busy: the current capture aborts without an ack, and the new command executes per REQ-017/018; a cmd 0 while busy also returns the state to IDLE.
REQ-025 X or Y outside the actual frame size leads to the timeout path.
REQ-026 Passthrough: out_* equals vid_* delayed by exactly one cycle, including valid, sof and eol.
REQ-027 Marker: when sw_out_port[15] = 1 and a valid input beat has x == X or y == Y, that beat's out_r/g/b take red/green/blue_out_port, sampled in the same cycle; controls are unaffected.
REQ-028 The marker does not depend on the capture state.
REQ-029 Beats with vid_valid = 0 are ignored by the counters, capture and marker logic; output colour on invalid beats is passthrough.

Reset
REQ-030 While reset_reset_n = 0 at a rising edge, the following clear to zero: all outputs, X, Y, the x/y counters, the frame counter, the line count, the registered request bit and the ack toggle; state goes to IDLE.
REQ-031 Reset mid-capture abandons the capture with no ack.
REQ-032 The registered request bit resets to 0, so a sw_out_port[17] = 1 present at reset release counts as one request.
REQ-033 The block assumes the first valid beat after reset may not be a sof; the counters run from 0 but capture waits for a sof.

Verification
REQ-034 Set X = 5, then arm Y = 2, on a 16x8 frame with pixel (5,2) = 0x11/0x22/0x33 -> rgb_in = 11/22/33, capture valid = 1, busy = 0, ack toggled twice total.
REQ-035 Arm with X = 0, Y = 0 -> the sof beat itself is captured; ack toggles on the cycle after the sof beat.
REQ-036 Arm with Y = 20 on a 16x8 frame, TIMEOUT_FRAMES = 3 -> error = 1 at the edge ending the third sof beat after SCAN entry; capture valid = 0; rgb_in unchanged.
REQ-037 Marker enabled, X = 3, Y = 1, marker colour FF/00/FF -> every beat in column 3 and row 1 outputs FF/00/FF one cycle later; all other beats pass through unchanged; sw_in_port[9:0] = 8 after the second sof.
REQ-038 Arm, then issue a new arm with Y = 4 before the first match -> no ack for the first arm; a single ack arrives on capture at row 4.
REQ-039 Assert reset while in SCAN -> the next cycle shows all outputs 0 and busy 0; a subsequent arm works normally.
